// File: rtl/vga_timing_pkg.sv
// Timing constants, state encoding and pixel payload for the 800x600@72Hz VGA timing monitor.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL  = 1040;
    localparam int unsigned H_SYNC   = 120;
    localparam int unsigned H_BP     = 64;
    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned V_TOTAL  = 666;
    localparam int unsigned V_SYNC   = 6;
    localparam int unsigned V_BP     = 23;
    localparam int unsigned V_ACTIVE = 600;

    localparam int unsigned H_POS_W     = 11;
    localparam int unsigned V_POS_W     = 10;
    localparam int unsigned FRAME_CNT_W = 16;

    // Active window, inclusive bounds in h_pos / v_pos coordinates
    localparam int unsigned H_ACT_FIRST = H_SYNC + H_BP;
    localparam int unsigned H_ACT_LAST  = H_ACT_FIRST + H_ACTIVE - 1;
    localparam int unsigned V_ACT_FIRST = V_SYNC + V_BP;
    localparam int unsigned V_ACT_LAST  = V_ACT_FIRST + V_ACTIVE - 1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        ERROR   = 2'd3
    } mon_state_e;

    typedef struct packed {
        logic [1:0] red;
        logic [1:0] green;
        logic [1:0] blue;
    } rgb_t;

endpackage

// File: rtl/sync_pulse_meter.sv
// Position, period and high-width counters for one sync signal; tick is the counting unit
// (every clock for H, every hrise for V).
module sync_pulse_meter #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         sync,
    input  logic         tick,
    input  logic         rise,
    output logic [W-1:0] pos_c,
    output logic [W-1:0] period_c,
    output logic         sat_c,
    output logic [W-1:0] period,
    output logic [W-1:0] width,
    output logic         valid
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] pos_q;
    logic [W-1:0] width_d;
    logic         pend_q;
    logic         start_c;

    // A rise arms the restart; the position zeroes on the first tick at or after it
    assign start_c = tick & (rise | pend_q);

    always_comb begin
        pos_c = pos_q;
        if (start_c) begin
            pos_c = '0;
        end else if (tick && (pos_q != CNT_MAX)) begin
            pos_c = pos_q + W'(1);
        end
    end

    assign sat_c    = (pos_c == CNT_MAX);
    assign period_c = (pos_q == CNT_MAX) ? CNT_MAX : pos_q + W'(tick);

    always_comb begin
        width_d = width;
        if (rise) begin
            width_d = W'(tick);
        end else if (sync && tick && (width != CNT_MAX)) begin
            width_d = width + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            pend_q <= 1'b0;
            period <= '0;
            width  <= '0;
            valid  <= 1'b0;
        end else if (clear) begin
            pos_q  <= '0;
            pend_q <= 1'b0;
            period <= '0;
            width  <= '0;
            valid  <= 1'b0;
        end else begin
            pos_q  <= pos_c;
            pend_q <= (rise | pend_q) & ~tick;
            width  <= width_d;
            if (rise) begin
                period <= period_c;
                valid  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// Checks VGA sync timing against 800x600@72Hz, tracks lock and raises sticky timing and
// blanking errors.
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL_CFG  = H_TOTAL,
    parameter int unsigned H_SYNC_CFG   = H_SYNC,
    parameter int unsigned H_BP_CFG     = H_BP,
    parameter int unsigned H_ACTIVE_CFG = H_ACTIVE,
    parameter int unsigned V_TOTAL_CFG  = V_TOTAL,
    parameter int unsigned V_SYNC_CFG   = V_SYNC,
    parameter int unsigned V_BP_CFG     = V_BP,
    parameter int unsigned V_ACTIVE_CFG = V_ACTIVE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   h_sync,
    input  logic                   v_sync,
    input  logic [1:0]             red_in,
    input  logic [1:0]             green_in,
    input  logic [1:0]             blue_in,
    input  logic                   clear,
    output logic                   locked,
    output logic                   h_err,
    output logic                   v_err,
    output logic                   blank_err,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [H_POS_W-1:0]     h_period,
    output logic [V_POS_W-1:0]     v_lines
);

    localparam int unsigned H_LO = H_SYNC_CFG + H_BP_CFG;
    localparam int unsigned H_HI = H_LO + H_ACTIVE_CFG - 1;
    localparam int unsigned V_LO = V_SYNC_CFG + V_BP_CFG;
    localparam int unsigned V_HI = V_LO + V_ACTIVE_CFG - 1;

    logic h_q, v_q;
    logic hrise, hfall, vrise, vfall;

    // Edges are taken against the live input so there is no detection lag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            h_q <= h_sync;
            v_q <= v_sync;
        end
    end

    assign hrise = h_sync & ~h_q;
    assign hfall = ~h_sync & h_q;
    assign vrise = v_sync & ~v_q;
    assign vfall = ~v_sync & v_q;

    logic [H_POS_W-1:0] h_pos_c, h_period_c, h_width;
    logic [V_POS_W-1:0] v_pos_c, v_period_c, v_width;
    logic               h_sat_c, v_sat_c, h_valid, v_valid;

    sync_pulse_meter #(.W(H_POS_W)) u_h_meter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .sync     (h_sync),
        .tick     (1'b1),
        .rise     (hrise),
        .pos_c    (h_pos_c),
        .period_c (h_period_c),
        .sat_c    (h_sat_c),
        .period   (h_period),
        .width    (h_width),
        .valid    (h_valid)
    );

    sync_pulse_meter #(.W(V_POS_W)) u_v_meter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .sync     (v_sync),
        .tick     (hrise),
        .rise     (vrise),
        .pos_c    (v_pos_c),
        .period_c (v_period_c),
        .sat_c    (v_sat_c),
        .period   (v_lines),
        .width    (v_width),
        .valid    (v_valid)
    );

    logic h_mis_c, v_mis_c, mis_c;

    assign h_mis_c = h_valid & ((hrise & (h_period_c != H_POS_W'(H_TOTAL_CFG)))
                              | (hfall & (h_width != H_POS_W'(H_SYNC_CFG)))
                              | h_sat_c);
    assign v_mis_c = v_valid & ((vrise & (v_period_c != V_POS_W'(V_TOTAL_CFG)))
                              | (vfall & (v_width != V_POS_W'(V_SYNC_CFG)))
                              | v_sat_c);
    assign mis_c   = h_mis_c | v_mis_c;

    rgb_t pix;
    logic in_window_c;
    logic pix_lit_c;

    assign pix         = '{red: red_in, green: green_in, blue: blue_in};
    assign pix_lit_c   = (pix != '0);
    assign in_window_c = (h_pos_c >= H_POS_W'(H_LO)) && (h_pos_c <= H_POS_W'(H_HI))
                      && (v_pos_c >= V_POS_W'(V_LO)) && (v_pos_c <= V_POS_W'(V_HI));

    mon_state_e             state_q, state_d;
    logic                   bad_q, bad_d;
    logic                   locked_d, h_err_d, v_err_d, blank_err_d;
    logic [FRAME_CNT_W-1:0] frame_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // bad_q remembers a mismatch anywhere in the frame being measured
    always_comb begin
        state_d       = state_q;
        bad_d         = bad_q;
        h_err_d       = h_err;
        v_err_d       = v_err;
        blank_err_d   = blank_err;
        frame_count_d = frame_count;
        if (clear) begin
            state_d       = SEARCH;
            bad_d         = 1'b0;
            h_err_d       = 1'b0;
            v_err_d       = 1'b0;
            blank_err_d   = 1'b0;
            frame_count_d = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vrise) begin
                        state_d = MEASURE;
                        bad_d   = 1'b0;
                    end
                end
                MEASURE: begin
                    if (vrise) begin
                        if (!bad_q && !mis_c) begin
                            state_d = LOCKED;
                        end
                        bad_d = 1'b0;
                    end else if (mis_c) begin
                        bad_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (vrise) begin
                        frame_count_d = frame_count + FRAME_CNT_W'(1);
                    end
                    if (pix_lit_c && !in_window_c) begin
                        blank_err_d = 1'b1;
                    end
                    if (mis_c) begin
                        state_d = ERROR;
                        h_err_d = h_err | h_mis_c;
                        v_err_d = v_err | v_mis_c;
                    end
                end
                default: begin
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q       <= 1'b0;
            locked      <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            blank_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            bad_q       <= bad_d;
            locked      <= locked_d;
            h_err       <= h_err_d;
            v_err       <= v_err_d;
            blank_err   <= blank_err_d;
            frame_count <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a scaled-down timing: event-timestamp reference model,
// randomized pixels and error placement.
module tb_vga_timing_monitor;

    localparam int HT = 40, HS = 6, HB = 4, HA = 24;
    localparam int VT = 20, VS = 3, VB = 2, VA = 12;
    localparam int HLO = HS + HB, HHI = HS + HB + HA - 1;
    localparam int VLO = VS + VB, VHI = VS + VB + VA - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        h_sync = 1'b0, v_sync = 1'b0, clear = 1'b0;
    logic [1:0]  red_in = '0, green_in = '0, blue_in = '0;
    logic        locked, h_err, v_err, blank_err;
    logic [15:0] frame_count;
    logic [10:0] h_period;
    logic [9:0]  v_lines;

    vga_timing_monitor #(
        .H_TOTAL_CFG(HT), .H_SYNC_CFG(HS), .H_BP_CFG(HB), .H_ACTIVE_CFG(HA),
        .V_TOTAL_CFG(VT), .V_SYNC_CFG(VS), .V_BP_CFG(VB), .V_ACTIVE_CFG(VA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .clear(clear),
        .locked(locked), .h_err(h_err), .v_err(v_err), .blank_err(blank_err),
        .frame_count(frame_count), .h_period(h_period), .v_lines(v_lines)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: spec rules over event timestamps and hrise counts
    int cyc = 0;
    bit m_hq, m_vq;
    int m_mode;  // 0 search, 1 measure, 2 locked, 3 error
    bit m_bad, m_herr, m_verr, m_berr;
    int m_fc, m_hper, m_vlines;
    int last_hrise, h_rise_t, n_h, n_start, v_rise_nh;
    bit h_seen, v_seen, v_pend;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_clear();
        m_mode = 0; m_bad = 0; m_herr = 0; m_verr = 0; m_berr = 0;
        m_fc = 0; m_hper = 0; m_vlines = 0;
        last_hrise = cyc; h_rise_t = cyc; n_h = 0; n_start = 0; v_rise_nh = 0;
        h_seen = 0; v_seen = 0; v_pend = 0;
    endtask

    function automatic logic [40:0] dut_vec();
        return {locked, h_err, v_err, blank_err, frame_count, h_period, v_lines};
    endfunction

    function automatic logic [40:0] exp_vec();
        return {m_mode == 2, m_herr, m_verr, m_berr, 16'(m_fc), 11'(m_hper), 10'(m_vlines)};
    endfunction

    task automatic step(input bit h, input bit v, input logic [5:0] rgb, input bit clr);
        bit hr, hf, vr, vf, hmis, vmis, outside;
        int hpos, vpos, hper, vper, vw, nprev;
        h_sync = h; v_sync = v; {red_in, green_in, blue_in} = rgb; clear = clr;
        cyc++;
        hr = h && !m_hq; hf = !h && m_hq;
        vr = v && !m_vq; vf = !v && m_vq;
        nprev = n_h;
        if (hr) n_h++;
        hper = imin(cyc - last_hrise, 2047);
        hpos = hr ? 0 : hper;
        hmis = h_seen && ((hr && hper != HT) || (hf && (cyc - h_rise_t) != HS) || hpos == 2047);
        vper = imin(n_h - n_start, 1023);
        if (hr && (vr || v_pend)) n_start = n_h;
        vpos = imin(n_h - n_start, 1023);
        vw   = nprev - v_rise_nh;
        vmis = v_seen && ((vr && vper != VT) || (vf && vw != VS) || vpos == 1023);
        outside = !(hpos >= HLO && hpos <= HHI && vpos >= VLO && vpos <= VHI);
        if (hr) begin
            m_hper = hper; last_hrise = cyc; h_rise_t = cyc; h_seen = 1;
        end
        if (vr) begin
            m_vlines = vper; v_rise_nh = nprev; v_seen = 1;
        end
        v_pend = (vr || v_pend) && !hr;
        m_hq = h; m_vq = v;
        if (clr) begin
            model_clear();
        end else if (m_mode == 0) begin
            if (vr) begin m_mode = 1; m_bad = 0; end
        end else if (m_mode == 1) begin
            if (vr) begin
                if (!m_bad && !hmis && !vmis) m_mode = 2;
                m_bad = 0;
            end else if (hmis || vmis) m_bad = 1;
        end else if (m_mode == 2) begin
            if (vr) m_fc = (m_fc + 1) % 65536;
            if (rgb != 0 && outside) m_berr = 1;
            if (hmis || vmis) begin
                m_mode = 3; m_herr = m_herr | hmis; m_verr = m_verr | vmis;
            end
        end
        @(posedge clk);
        #1;
        check("outs", 64'(dut_vec()), 64'(exp_vec()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; h_sync = 0; v_sync = 0; clear = 0;
        {red_in, green_in, blue_in} = '0;
        #1;
        check("rst_async", 64'(dut_vec()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        m_hq = 0; m_vq = 0;
        model_clear();
        rst_n = 1'b1;
    endtask

    // One frame; inj0/inj1 encode line*1000+pixel for forced 6'h3F pixels
    task automatic send_frame(input int vs_w, input int bad_line, input int inj0, input int inj1,
                              input bit rnd, input int clr_line);
        logic [5:0] rgb;
        int len;
        for (int l = 0; l < VT; l++) begin
            len = (l == bad_line) ? HT + 1 : HT;
            for (int i = 0; i < len; i++) begin
                rgb = '0;
                if (rnd && i >= HLO && i <= HHI && l >= VLO && l <= VHI) rgb = 6'($urandom);
                if ((l * 1000 + i) == inj0 || (l * 1000 + i) == inj1) rgb = 6'h3F;
                step(i < HS, l < vs_w, rgb, (l == clr_line) && (i == 0));
            end
        end
    endtask

    task automatic good_frame();
        send_frame(VS, -1, -1, -1, 1'b1, -1);
    endtask

    task automatic clear_and_relock();
        step(1'b0, 1'b0, 6'h0, 1'b1);
        check("clr_herr", 64'(h_err), 64'(0));
        good_frame();
        good_frame();
        check("relock", 64'(locked), 64'(1));
        check("relock_fc", 64'(frame_count), 64'(0));
    endtask

    initial begin
        int bad, n;
        #2;
        do_reset();

        repeat (3) good_frame();
        check("lock_locked", 64'(locked), 64'(1));
        check("lock_fc", 64'(frame_count), 64'(1));
        check("lock_hper", 64'(h_period), 64'(HT));
        check("lock_vlines", 64'(v_lines), 64'(VT));
        check("lock_flags", 64'({h_err, v_err, blank_err}), 64'(0));

        bad = int'($urandom_range(1, VT - 2));
        send_frame(VS, bad, -1, -1, 1'b1, -1);
        check("hper_err", 64'(h_err), 64'(1));
        check("hper_unlock", 64'(locked), 64'(0));
        good_frame();
        check("hper_sticky", 64'(h_err), 64'(1));
        clear_and_relock();

        send_frame(VS - 1, -1, -1, -1, 1'b1, -1);
        check("vw_verr", 64'(v_err), 64'(1));
        check("vw_herr", 64'(h_err), 64'(0));
        check("vw_unlock", 64'(locked), 64'(0));
        clear_and_relock();

        send_frame(VS, -1, int'($urandom_range(0, VT - 1)) * 1000, -1, 1'b1, -1);
        check("blank_set", 64'(blank_err), 64'(1));
        check("blank_locked", 64'(locked), 64'(1));

        n = int'($urandom_range(50, 500));
        for (int k = 0; k < n; k++) step((k % HT) < HS, 1'b0, 6'h0, 1'b0);
        do_reset();
        good_frame();
        check("rst_nolock1", 64'(locked), 64'(0));
        good_frame();
        check("rst_relock", 64'(locked), 64'(1));

        repeat (3000) step(1'b0, 1'b0, 6'h0, 1'b0);
        check("miss_herr", 64'(h_err), 64'(1));
        check("miss_verr", 64'(v_err), 64'(0));
        check("miss_hper", 64'(h_period), 64'(HT));
        clear_and_relock();

        bad = int'($urandom_range(1, VT - 3));
        send_frame(VS, bad, -1, -1, 1'b1, bad + 1);
        check("clrbad_herr", 64'(h_err), 64'(0));
        check("clrbad_locked", 64'(locked), 64'(0));

        do_reset();
        repeat (3) send_frame(VS, -1, VLO * 1000 + HLO, VHI * 1000 + HHI, 1'b0, -1);
        check("corner_blank", 64'(blank_err), 64'(0));
        check("corner_locked", 64'(locked), 64'(1));
        send_frame(VS, -1, VLO * 1000 + HLO - 1, -1, 1'b0, -1);
        check("edge_blank", 64'(blank_err), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Consumes the VGA output bundle of the video card top: h_sync, v_sync and the 2-bit red/green/blue channels.
- Measures sync periods and pulse widths against the 800x600@72Hz timing and reports lock.
- Flags timing errors and non-black pixels during blanking. All flags are sticky.
- Synthesisable: used on-FPGA as a self-check and in simulation as the downstream checker.

Parameters:
H_TOTAL, 1040, clocks per line
H_SYNC, 120, h_sync high width in clocks
H_BP, 64, h back porch in clocks
H_ACTIVE, 800, visible pixels per line
V_TOTAL, 666, lines per frame
V_SYNC, 6, v_sync high width in lines
V_BP, 23, v back porch in lines
V_ACTIVE, 600, visible lines

Ports:
clk  input  1  pixel clock (the same clk as the video card)
rst_n  input  1  asynchronous active-low reset
h_sync  input  1  horizontal sync, active-high, synchronous to clk
v_sync  input  1  vertical sync, active-high, synchronous to clk
red_in  input  2  red channel
green_in  input  2  green channel
blue_in  input  2  blue channel
clear  input  1  synchronous clear of sticky flags, counters and state
locked  output  1  high while state is LOCKED
h_err  output  1  sticky horizontal timing error
v_err  output  1  sticky vertical timing error
blank_err  output  1  sticky nonzero colour outside the active window
frame_count  output  16  frames seen while LOCKED; wraps
h_period  output  11  last measured line period in clocks
v_lines  output  10  last measured frame period in lines

Behaviour:
- One clock, clk. rst_n is asynchronous active-low. While rst_n is low, every output is 0 and state is SEARCH.
- Edge detection:
  - h_q and v_q are registered copies of the sync inputs, reset to 0.
  - hrise = h_sync & ~h_q; hfall = ~h_sync & h_q. vrise and vfall are defined the same way.
  - Edges are combinational on the current input, so there is no lag.
- h_pos (11 bits):
  - 0 on an hrise cycle, else +1, saturating at 2047.
  - On hrise, h_period <= previous h_pos + 1.
  - h_hi counts cycles with h_sync high. On hfall it is checked against H_SYNC.
  - h_valid is set at the first hrise after reset or clear. No H checks run before it is set.
- v_pos (10 bits):
  - 0 at the hrise coincident with or following vrise, else +1 on each hrise, saturating at 1023.
  - On vrise, v_lines <= line count since the previous vrise.
  - v_hi counts hrises while v_sync is high. On vfall it is checked against V_SYNC.
- Mismatch means any of:
  - h_period != H_TOTAL;
  - h_hi != H_SYNC at hfall;
  - h_pos reaches 2047;
  - v_lines != V_TOTAL;
  - v_hi != V_SYNC at vfall;
  - v_pos reaches 1023.
- State machine (2 bits, encoding in the package):
  - SEARCH -> MEASURE on vrise.
  - MEASURE -> LOCKED on the next vrise if no mismatch occurred in the frame just ended. Otherwise stay in MEASURE, discard the frame and restart.
  - LOCKED -> ERROR on any mismatch. In the same cycle, the matching sticky flag (h_err or v_err) is set and locked drops.
  - ERROR stays until clear.
  - clear from any state -> SEARCH next cycle.
- Error flags and counters:
  - h_err and v_err are set only from LOCKED.
  - Mismatches in MEASURE do not set flags.
- blank_err: set when all of the following hold in the same cycle:
  - state is LOCKED;
  - {red_in,green_in,blue_in} != 0;
  - the pixel is outside the active window, h_pos in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [184, 983] and v_pos in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] = [29, 628].
- frame_count increments on each vrise while already LOCKED. The vrise that enters LOCKED does not count. Wraps 65535 -> 0.
- Simultaneous events:
  - clear wins over any error or edge in the same cycle.
  - An hrise coincident with a vrise is counted as line 0 of the new frame.
  - Coincident h and v mismatches set both flags.
- Reset mid-frame: everything returns to the reset state. Re-lock requires two fresh vrises.

Decomposition:
- Package vga_timing_pkg holds:
  - the 800x600@72 timing constants listed above;
  - the state encoding SEARCH=0, MEASURE=1, LOCKED=2, ERROR=3;
  - the derived active-window bounds.
- Sub-module sync_pulse_meter, instantiated twice:
  - Inputs: sync level, tick enable (1 for H; hrise for V).
  - Outputs: position, period and width counters, and saturation, for the 11-bit H and 10-bit V instances.
- Top-level vga_timing_monitor holds the edge detectors, FSM, window compare and sticky flags.

Test Plan:
- Lock and frame count: ideal 1040/120 H, 666/6 V, three frames -> locked=1 at the second vrise, h_period=1040, v_lines=666, frame_count=1 at the third vrise, all error flags 0.
- H period error: while locked, one line of 1041 clocks -> at that hrise h_err=1, locked=0, state ERROR. Stays set after a further good frame until clear. After clear, two good frames re-lock.
- V sync width error: while locked, v_sync high for 5 lines -> v_err=1 at vfall, h_err stays 0.
- Blanking check: while locked, RGB=6'h3F at h_pos=0 -> blank_err=1. On a fresh run, RGB=6'h3F only at h_pos=184, v_pos=29 and h_pos=983, v_pos=628 -> blank_err=0.
- Missing sync: h_sync held low 3000 cycles while locked -> h_pos holds 2047, h_err=1. No wrap to 0.
- Reset and clear: rst_n low mid-frame -> all outputs 0 immediately, relock after two vrises. A clear in the same cycle as a bad hrise -> state SEARCH, h_err=0.
